// File: rtl/fma_add_norm_r4.sv
// FMA final add stage: signed mantissa add/sub, then normalize, round and
// pack to IEEE-754 single, as a two-deep valid/ready pipeline.
module fma_add_norm_r4 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign1,
   input  logic        sign2,
   input  logic [7:0]  exp_res,
   input  logic [47:0] mant1_aligned,
   input  logic [47:0] mant2_aligned,
   input  logic        nan,
   input  logic        inf1,
   input  logic        inf2,
   input  logic [2:0]  rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  fflags
);

   localparam logic [2:0] RTZ = 3'b001;
   localparam logic [2:0] RDN = 3'b010;
   localparam logic [2:0] RUP = 3'b011;
   localparam logic [2:0] RMM = 3'b100;

   logic        va_q;
   logic [48:0] sum_q, sum_d;
   logic        sgn_q, sgn_d;
   logic        zsgn_q, zsgn_d;
   logic [7:0]  exp_q;
   logic [2:0]  rm_q;
   logic        spc_q, spc_d;
   logic        spc_nv_q, spc_nv_d;
   logic [31:0] spc_res_q, spc_res_d;

   logic        ready_b;
   logic [31:0] res_d;
   logic [4:0]  flg_d;

   assign ready_b  = !out_valid | out_ready;
   assign in_ready = !va_q | ready_b;

   // Stage A: sign-magnitude add, plus special-operand resolution
   always_comb begin
      sum_d = '0;
      sgn_d = sign1;
      if (sign1 == sign2) begin
         sum_d = {1'b0, mant1_aligned} + {1'b0, mant2_aligned};
      end else if (mant1_aligned >= mant2_aligned) begin
         sum_d = {1'b0, mant1_aligned - mant2_aligned};
      end else begin
         sum_d = {1'b0, mant2_aligned - mant1_aligned};
         sgn_d = sign2;
      end
      zsgn_d = (sign1 == sign2) ? (sign1 & sign2) : (rm == RDN);
      spc_d     = 1'b1;
      spc_nv_d  = 1'b0;
      spc_res_d = 32'h7FC0_0000;
      if (nan) begin
         spc_res_d = 32'h7FC0_0000;
      end else if (inf1 && inf2 && (sign1 != sign2)) begin
         spc_nv_d = 1'b1;
      end else if (inf1) begin
         spc_res_d = {sign1, 8'hFF, 23'd0};
      end else if (inf2) begin
         spc_res_d = {sign2, 8'hFF, 23'd0};
      end else begin
         spc_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         va_q      <= 1'b0;
         sum_q     <= '0;
         sgn_q     <= 1'b0;
         zsgn_q    <= 1'b0;
         exp_q     <= '0;
         rm_q      <= '0;
         spc_q     <= 1'b0;
         spc_nv_q  <= 1'b0;
         spc_res_q <= '0;
      end else if (in_ready) begin
         va_q <= in_valid;
         if (in_valid) begin
            sum_q     <= sum_d;
            sgn_q     <= sgn_d;
            zsgn_q    <= zsgn_d;
            exp_q     <= exp_res;
            rm_q      <= rm;
            spc_q     <= spc_d;
            spc_nv_q  <= spc_nv_d;
            spc_res_q <= spc_res_d;
         end
      end
   end

   function automatic logic [5:0] lzc48(input logic [47:0] v);
      lzc48 = 6'd48;
      for (int i = 0; i < 48; i++)
         if (v[i]) lzc48 = 6'(47 - i);
   endfunction

   logic [47:0] m;
   logic        st0, st, g, nx, inc, ovinf;
   logic [7:0]  emax, sh;
   logic [9:0]  e, ef;
   logic [24:0] rnd;
   logic [23:0] mant;

   // Stage B: normalize (shift capped so exponent never drops below 1)
   always_comb begin
      m    = sum_q[47:0];
      st0  = 1'b0;
      emax = exp_q - 8'd1;
      sh   = '0;
      e    = '0;
      if (sum_q[48]) begin
         m   = sum_q[48:1];
         st0 = sum_q[0];
         e   = {2'b0, exp_q} + 10'd1;
      end else if (exp_q != 8'd0) begin
         sh = ({2'b0, lzc48(sum_q[47:0])} < emax) ?
              {2'b0, lzc48(sum_q[47:0])} : emax;
         m  = sum_q[47:0] << sh;
         e  = m[47] ? ({2'b0, exp_q} - {2'b0, sh}) : 10'd0;
      end else begin
         e = m[47] ? 10'd1 : 10'd0;
      end
      g  = m[23];
      st = (|m[22:0]) | st0;
      nx = g | st;
      case (rm_q)
         RTZ:     inc = 1'b0;
         RDN:     inc = sgn_q & nx;
         RUP:     inc = !sgn_q & nx;
         RMM:     inc = g;
         default: inc = g & (st | m[24]);
      endcase
      rnd = {1'b0, m[47:24]} + {24'd0, inc};
      if (rnd[24]) begin
         mant = 24'h80_0000;
         ef   = e + 10'd1;
      end else begin
         mant = rnd[23:0];
         ef   = (e == 10'd0 && rnd[23]) ? 10'd1 : e;
      end
      ovinf = !(rm_q == RTZ || (rm_q == RUP && sgn_q) ||
                (rm_q == RDN && !sgn_q));
      if (spc_q) begin
         res_d = spc_res_q;
         flg_d = {spc_nv_q, 4'b0};
      end else if (sum_q == 49'd0) begin
         res_d = {zsgn_q, 31'd0};
         flg_d = '0;
      end else if (ef >= 10'd255) begin
         res_d = ovinf ? {sgn_q, 8'hFF, 23'd0} : {sgn_q, 31'h7F7F_FFFF};
         flg_d = 5'b00101;
      end else begin
         res_d = {sgn_q, ef[7:0], mant[22:0]};
         flg_d = {3'b0, (ef == 10'd0) & nx, nx};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         fflags    <= '0;
      end else if (ready_b) begin
         out_valid <= va_q;
         if (va_q) begin
            result <= res_d;
            fflags <= flg_d;
         end
      end
   end

endmodule
